// File: rtl/bw_divider_pkg.sv
// Shared types and helpers for the bw_divider iterative restoring divider.
package bw_divider_pkg;

    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_IW = 6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } bw_div_state_e;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Magnitude of a w-bit value; the most-negative value maps to its own bit pattern.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                 input int unsigned      w,
                                                 input logic             is_signed);
        if (is_signed && x[MAX_IW'(w - 1)]) begin
            return (~x + MAX_W'(1)) & width_mask(w);
        end
        return x & width_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] neg_cond(input logic [MAX_W-1:0] x,
                                                  input int unsigned      w,
                                                  input logic             neg);
        if (neg) begin
            return (~x + MAX_W'(1)) & width_mask(w);
        end
        return x & width_mask(w);
    endfunction

endpackage

// File: rtl/bw_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module bw_div_step #(
    parameter int unsigned NBITS_B = 4
) (
    input  logic [NBITS_B:0]   rem_i,
    input  logic               msb_i,
    input  logic [NBITS_B-1:0] dvs_i,
    output logic [NBITS_B:0]   next_rem_o,
    output logic               q_bit_o
);

    logic [NBITS_B:0] shifted;
    logic [NBITS_B:0] dvs_ext;
    logic             unused_rem_msb;

    // The top remainder bit is always clear between steps, so it is shifted out.
    assign unused_rem_msb = rem_i[NBITS_B];
    assign shifted        = {rem_i[NBITS_B-1:0], msb_i};
    assign dvs_ext        = {1'b0, dvs_i};
    assign q_bit_o        = (shifted >= dvs_ext);
    assign next_rem_o     = q_bit_o ? (shifted - dvs_ext) : shifted;

endmodule

// File: rtl/bw_divider.sv
// Iterative signed/unsigned restoring divider with valid/ready on both sides.
// Optional BW_DIVIDER_ZERO_SHORTCUT_EN skips the iteration for a zero dividend or divisor.
module bw_divider
    import bw_divider_pkg::*;
#(
    parameter int unsigned NBITS_A = 8,
    parameter int unsigned NBITS_B = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [NBITS_A-1:0] a_i,
    input  logic               a_is_signed_i,
    input  logic [NBITS_B-1:0] b_i,
    input  logic               b_is_signed_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [NBITS_A-1:0] q_o,
    output logic [NBITS_A-1:0] r_o,
    output logic               div_by_zero_o
);

    localparam int unsigned CW = $clog2(NBITS_A);
    localparam int unsigned RW = NBITS_B + 1;

    if (NBITS_A < 2 || NBITS_A > MAX_W || NBITS_B < 2 || NBITS_B > NBITS_A) begin : g_param_check
        $error("bw_divider: requires 2 <= NBITS_B <= NBITS_A <= 64");
    end

    bw_div_state_e      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NBITS_A-1:0] dvd_q, dvd_d;
    logic [NBITS_B-1:0] dvs_q, dvs_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [NBITS_A-1:0] a_q, a_d;
    logic               a_sgn_q, a_sgn_d;
    logic               b_neg_q, b_neg_d;
    logic [NBITS_A-1:0] q_q, q_d;
    logic [NBITS_A-1:0] r_q, r_d;
    logic               dbz_q, dbz_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [NBITS_A-1:0] a_abs;
    logic [NBITS_B-1:0] b_abs;
    logic [RW-1:0]      step_rem;
    logic               step_qbit;
    logic               neg_r;
    logic               neg_q;

    assign a_abs = NBITS_A'(abs_val(MAX_W'(a_i), NBITS_A, a_is_signed_i));
    assign b_abs = NBITS_B'(abs_val(MAX_W'(b_i), NBITS_B, b_is_signed_i));
    assign neg_r = a_sgn_q & a_q[NBITS_A-1];
    assign neg_q = neg_r ^ b_neg_q;

    bw_div_step #(
        .NBITS_B (NBITS_B)
    ) u_step (
        .rem_i      (rem_q),
        .msb_i      (dvd_q[NBITS_A-1]),
        .dvs_i      (dvs_q),
        .next_rem_o (step_rem),
        .q_bit_o    (step_qbit)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        a_d     = a_q;
        a_sgn_d = a_sgn_q;
        b_neg_d = b_neg_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    a_d     = a_i;
                    a_sgn_d = a_is_signed_i;
                    b_neg_d = b_is_signed_i & b_i[NBITS_B-1];
                    dvd_d   = a_abs;
                    dvs_d   = b_abs;
                    cnt_d   = CW'(NBITS_A - 1);
                    rem_d   = '0;
                    state_d = CALC;
`ifdef BW_DIVIDER_ZERO_SHORTCUT_EN
                    if (a_abs == '0 || b_abs == '0) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[NBITS_A-2:0], step_qbit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                // After the last step dvd_q holds |q| and rem_q holds |r|.
                if (dvs_q == '0) begin
                    q_d   = '1;
                    r_d   = a_q;
                    dbz_d = 1'b1;
                end else begin
                    q_d   = NBITS_A'(neg_cond(MAX_W'(dvd_q), NBITS_A, neg_q));
                    r_d   = NBITS_A'(neg_cond(MAX_W'(rem_q[NBITS_B-1:0]), NBITS_A, neg_r));
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            a_q         <= '0;
            a_sgn_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            a_q         <= a_d;
            a_sgn_q     <= a_sgn_d;
            b_neg_q     <= b_neg_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign q_o           = q_q;
    assign r_o           = r_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_bw_divider.sv
// Self-checking bench for bw_divider (NBITS_A=8, NBITS_B=4) against an arithmetic model.
module tb_bw_divider;

    localparam int unsigned NA = 8;
    localparam int unsigned NB = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [NA-1:0] a_i;
    logic          a_is_signed_i;
    logic [NB-1:0] b_i;
    logic          b_is_signed_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [NA-1:0] q_o;
    logic [NA-1:0] r_o;
    logic          div_by_zero_o;

    always #5 clk_i = ~clk_i;

    bw_divider #(
        .NBITS_A (NA),
        .NBITS_B (NB)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .a_i           (a_i),
        .a_is_signed_i (a_is_signed_i),
        .b_i           (b_i),
        .b_is_signed_i (b_is_signed_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .q_o           (q_o),
        .r_o           (r_o),
        .div_by_zero_o (div_by_zero_o)
    );

    typedef struct {
        logic [NA-1:0] q;
        logic [NA-1:0] r;
        logic          dbz;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_edge = 0;
    int   prev_acc = 0;
    int   done_cnt = 0;
    int   meas_lat = 0;
    bit   seen_valid = 1'b0;
    logic [NA-1:0] last_q;
    logic [NA-1:0] last_r;
    logic          last_dbz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // Integer division in SV truncates toward zero, matching the required semantics.
    function automatic exp_t model(input logic [NA-1:0] a, input logic as,
                                   input logic [NB-1:0] b, input logic bs);
        longint av, bv, qv, rv;
        exp_t   e;
        av = as ? longint'($signed(a)) : longint'(a);
        bv = bs ? longint'($signed(b)) : longint'(b);
        if (bv == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            qv    = av / bv;
            rv    = av % bv;
            e.q   = qv[NA-1:0];
            e.r   = rv[NA-1:0];
            e.dbz = 1'b0;
        end
        e.lat = NA + 2;
`ifdef BW_DIVIDER_ZERO_SHORTCUT_EN
        if (av == 0 || bv == 0) e.lat = 2;
`endif
        return e;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Compare process: values seen at a negedge are those sampled at edge cyc+1.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_q.delete();
            seen_valid = 1'b0;
        end else begin
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid_o), 32'd0);
                end else begin
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        meas_lat   = cyc + 1 - acc_edge;
                        chk("latency", 32'(meas_lat), 32'(exp_q[0].lat));
                    end
                    chk("q", 32'(q_o), 32'(exp_q[0].q));
                    chk("r", 32'(r_o), 32'(exp_q[0].r));
                    chk("dbz", 32'(div_by_zero_o), 32'(exp_q[0].dbz));
                    chk("in_ready_busy", 32'(in_ready_o), 32'd0);
                    if (out_ready_i) begin
                        last_q   = q_o;
                        last_r   = r_o;
                        last_dbz = div_by_zero_o;
                        void'(exp_q.pop_front());
                        seen_valid = 1'b0;
                        done_cnt++;
                    end
                end
            end
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back(model(a_i, a_is_signed_i, b_i, b_is_signed_i));
                prev_acc = acc_edge;
                acc_edge = cyc + 1;
            end
        end
    end

    task automatic issue(input logic [NA-1:0] a, input logic as, input logic [NB-1:0] b, input logic bs);
        int g = 0;
        while (!in_ready_o) begin
            @(posedge clk_i); #1;
            g++;
            if (g > 100) begin
                timeout("in_ready_wait");
                return;
            end
        end
        in_valid_i    = 1'b1;
        a_i           = a;
        a_is_signed_i = as;
        b_i           = b;
        b_is_signed_i = bs;
        @(posedge clk_i); #1;
        in_valid_i    = 1'b0;
        a_i           = NA'($urandom);
        b_i           = NB'($urandom);
        a_is_signed_i = 1'($urandom);
        b_is_signed_i = 1'($urandom);
    endtask

    task automatic wait_done(input int target);
        int g = 0;
        while (done_cnt < target) begin
            @(posedge clk_i); #1;
            g++;
            if (g > 200) begin
                timeout("result_wait");
                return;
            end
        end
    endtask

    task automatic run(input logic [NA-1:0] a, input logic as, input logic [NB-1:0] b, input logic bs);
        int d0 = done_cnt;
        issue(a, as, b, bs);
        wait_done(d0 + 1);
    endtask

    typedef struct {
        logic [NA-1:0] a;
        logic          as;
        logic [NB-1:0] b;
        logic          bs;
    } vec_t;

    vec_t vecs[$];
    logic [NA-1:0] held_q;
    logic [NA-1:0] held_r;
    int d0;
    int g;

    initial begin
        rst_ni        = 1'b0;
        in_valid_i    = 1'b0;
        out_ready_i   = 1'b1;
        a_i           = '0;
        b_i           = '0;
        a_is_signed_i = 1'b0;
        b_is_signed_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_q", 32'(q_o), 32'd0);
        chk("rst_r", 32'(r_o), 32'd0);
        chk("rst_dbz", 32'(div_by_zero_o), 32'd0);

        run(8'd100, 1'b0, 4'd7, 1'b0);
        chk("unsigned_q", 32'(last_q), 32'h0E);
        chk("unsigned_r", 32'(last_r), 32'h02);
        chk("unsigned_lat", 32'(meas_lat), 32'd10);

        run(8'h9C, 1'b1, 4'h7, 1'b1);
        chk("signed_q", 32'(last_q), 32'hF2);
        chk("signed_r", 32'(last_r), 32'hFE);

        run(8'h9C, 1'b1, 4'hF, 1'b0);
        chk("mixed_q", 32'(last_q), 32'hFA);
        chk("mixed_r", 32'(last_r), 32'hF6);

        run(8'h55, 1'b0, 4'h0, 1'b0);
        chk("dbz_q", 32'(last_q), 32'hFF);
        chk("dbz_r", 32'(last_r), 32'h55);
        chk("dbz_flag", 32'(last_dbz), 32'd1);
`ifdef BW_DIVIDER_ZERO_SHORTCUT_EN
        chk("dbz_lat", 32'(meas_lat), 32'd2);
`else
        chk("dbz_lat", 32'(meas_lat), 32'd10);
`endif

        run(8'h80, 1'b1, 4'hF, 1'b1);
        chk("ovf_q", 32'(last_q), 32'h80);
        chk("ovf_r", 32'(last_r), 32'h00);
        chk("ovf_dbz", 32'(last_dbz), 32'd0);

        // Extra patterns checked by the model only.
        vecs.push_back('{8'h81, 1'b1, 4'h8, 1'b1});
        vecs.push_back('{8'hFF, 1'b0, 4'hF, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 4'h5, 1'b1});
        vecs.push_back('{8'h9C, 1'b1, 4'h0, 1'b1});
        vecs.push_back('{8'h7F, 1'b1, 4'h9, 1'b1});
        vecs.push_back('{8'h03, 1'b0, 4'hF, 1'b0});
        vecs.push_back('{8'h80, 1'b0, 4'h8, 1'b1});
        foreach (vecs[i]) run(vecs[i].a, vecs[i].as, vecs[i].b, vecs[i].bs);
        chk("neg_div_q", 32'(last_q), 32'hF0);

        // Back-to-back throughput.
        d0 = done_cnt;
        issue(8'd200, 1'b0, 4'd9, 1'b0);
        issue(8'h32, 1'b1, 4'hD, 1'b1);
        wait_done(d0 + 2);
        chk("throughput", 32'(acc_edge - prev_acc), 32'd11);

        // Backpressure in DONE with ignored input pulses.
        out_ready_i = 1'b0;
        d0 = done_cnt;
        issue(8'd100, 1'b0, 4'd7, 1'b0);
        g = 0;
        while (!out_valid_o && g < 50) begin
            @(posedge clk_i); #1;
            g++;
        end
        if (!out_valid_o) timeout("bp_valid_wait");
        held_q = q_o;
        held_r = r_o;
        for (int k = 0; k < 5; k++) begin
            in_valid_i = (k % 2 == 0);
            a_i        = 8'h11;
            b_i        = 4'h3;
            @(posedge clk_i); #1;
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
            chk("bp_valid", 32'(out_valid_o), 32'd1);
            chk("bp_q_hold", 32'(q_o), 32'h0E);
            chk("bp_r_hold", 32'(r_o), 32'h02);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        wait_done(d0 + 1);
        run(8'h9C, 1'b1, 4'h7, 1'b1);
        chk("post_bp_q", 32'(last_q), 32'hF2);

        // Reset while the counter is at 3.
        d0 = done_cnt;
        issue(8'd123, 1'b0, 4'd5, 1'b0);
        repeat (4) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
        chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_q", 32'(q_o), 32'd0);
        for (int k = 0; k < 15; k++) begin
            @(posedge clk_i); #1;
            chk("midrst_no_valid", 32'(out_valid_o), 32'd0);
        end
        chk("midrst_no_result", 32'(done_cnt), 32'(d0));
        run(8'd100, 1'b0, 4'd7, 1'b0);
        chk("post_rst_q", 32'(last_q), 32'h0E);
        chk("post_rst_r", 32'(last_r), 32'h02);

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
